// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Multi-channel rising-edge event scheduler. Each din bit has its own
//   rising-edge detector. A detected edge becomes a pending event, and a
//   round-robin arbiter presents the pending events one at a time on a single
//   valid/ready port, tagged with the originating channel id.
//
// Ports
//   clk        system clock, all state updates on posedge
//   RESET      synchronous active-high reset
//   din        raw channel levels (N_CH), synchronous to clk
//   evt_valid  event offered on evt_id
//   evt_id     channel index of the offered event (ID_W)
//   evt_ready  consumer accepts when high together with evt_valid
//   pending    registered pending-event flags (N_CH)
//   overflow   sticky per-channel lost-event flags (N_CH)
//   ovf_clr    one-cycle pulse, clears overflow and drop_cnt
//   drop_cnt   saturating count of lost events over all channels (CNT_W)
//
// FSM states
//   state | meaning
//   IDLE  | nothing offered; picks the next pending channel, if any
//   OFFER | evt_valid/evt_id held stable until the consumer accepts

module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [N_CH-1:0]  din,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overflow,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  RR_INIT = ID_W'(N_CH - 1);

  state_t           state, state_nxt;
  logic [N_CH-1:0]  prev_din;
  logic [ID_W-1:0]  rr_last, rr_nxt;
  logic             valid_nxt;
  logic [ID_W-1:0]  id_nxt;

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  accept_vec;
  logic [N_CH-1:0]  drop_vec;
  logic [N_CH-1:0]  pending_nxt;
  logic [N_CH-1:0]  overflow_nxt;
  logic [4:0]       drop_num;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;

  logic             sel_found;
  logic [ID_W-1:0]  sel_id;

  assign rise = din & ~prev_din;

  always_comb begin
    accept_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept_vec[i] = evt_valid & evt_ready & (evt_id == ID_W'(i));
    end
  end

  // A rise coinciding with the accept of the same channel re-arms it rather
  // than counting as a drop: the accepted event is the older edge.
  assign drop_vec     = rise & pending & ~accept_vec;
  assign pending_nxt  = (pending & ~accept_vec) | rise;
  assign overflow_nxt = (ovf_clr ? '0 : overflow) | drop_vec;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_num = drop_num + 5'(drop_vec[i]);
    end
  end

  // Clear is applied before adding this cycle's drops so a simultaneous drop
  // survives the clear.
  always_comb begin
    cnt_base = ovf_clr ? '0 : drop_cnt;
    cnt_sum  = SUM_W'(cnt_base) + SUM_W'(drop_num);
    cnt_nxt  = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  // Round-robin search: first set pending bit starting just after rr_last.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!sel_found && pending[(int'(rr_last) + k) % N_CH]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'((int'(rr_last) + k) % N_CH);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = evt_valid;
    id_nxt    = evt_id;
    rr_nxt    = rr_last;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (sel_found) begin
          valid_nxt = 1'b1;
          id_nxt    = sel_id;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_nxt = 1'b0;
          rr_nxt    = evt_id;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_last   <= RR_INIT;
      prev_din  <= '0;
      pending   <= '0;
      overflow  <= '0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      evt_valid <= valid_nxt;
      evt_id    <= id_nxt;
      rr_last   <= rr_nxt;
      prev_din  <= din;
      pending   <= pending_nxt;
      overflow  <= overflow_nxt;
      drop_cnt  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N_CH=4, ID_W=2, CNT_W=8).
// Inputs change 1ns after posedge; outputs are sampled at that same point,
// before the inputs for the next cycle are applied.

module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       RESET;
  logic [3:0] din;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       ovf_clr;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  edge_event_arbiter #(.N_CH(4), .ID_W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .din       (din),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; din = 4'b0000; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_valid",    32'(evt_valid), 32'd0);
    chk("rst_id",       32'(evt_id),    32'd0);
    chk("rst_pending",  32'(pending),   32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_drop",     32'(drop_cnt),  32'd0);

    // Channels 0 and 2 held high across reset release
    RESET = 1'b0; din = 4'b0101; evt_ready = 1'b1;
    tick();
    chk("t1_pending", 32'(pending),   32'b0101);
    chk("t1_valid0",  32'(evt_valid), 32'd0);
    tick();
    chk("t1_ev0", 32'({evt_valid, evt_id}), 32'b100);
    tick();
    chk("t1_bubble", 32'(evt_valid), 32'd0);
    chk("t1_pend2",  32'(pending),   32'b0100);
    tick();
    chk("t1_ev2", 32'({evt_valid, evt_id}), 32'b110);
    tick();
    chk("t1_done_pend", 32'(pending), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_no_more", 32'({evt_valid, pending}), 32'd0);
    din = 4'b0000;

    // All four channels pulse together
    do_reset();
    din = 4'b1111;
    tick();
    din = 4'b0000;
    chk("t2_pending", 32'(pending), 32'b1111);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_grant", 32'({evt_valid, evt_id}), 32'({1'b1, 2'(k)}));
      tick();
      chk("t2_bubble", 32'(evt_valid), 32'd0);
    end
    chk("t2_empty", 32'(pending), 32'd0);
    din = 4'b1001;
    tick();
    din = 4'b0000;
    tick();
    chk("t2_wrap0", 32'({evt_valid, evt_id}), 32'b100);
    tick();
    tick();
    chk("t2_wrap3", 32'({evt_valid, evt_id}), 32'b111);
    tick();
    chk("t2_wrap_end", 32'({evt_valid, pending}), 32'd0);

    // Channel 1 held in OFFER with evt_ready low
    evt_ready = 1'b0; din = 4'b0010;
    tick();
    din = 4'b0000;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_stable", 32'({evt_valid, evt_id}), 32'b101);
      tick();
    end
    evt_ready = 1'b1;
    tick();
    chk("t3_acc_valid", 32'(evt_valid), 32'd0);
    chk("t3_acc_pend",  32'(pending),   32'd0);

    // Overflow on channel 2
    evt_ready = 1'b0; din = 4'b0100;
    tick();
    din = 4'b0000;
    tick();
    chk("t4_offer", 32'({evt_valid, evt_id}), 32'b110);
    din = 4'b0100; tick();
    din = 4'b0000; tick();
    din = 4'b0100; tick();
    din = 4'b0000; tick();
    chk("t4_ovf",  32'(overflow), 32'b0100);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_clr_ovf",  32'(overflow), 32'd0);
    chk("t4_clr_drop", 32'(drop_cnt), 32'd0);
    ovf_clr = 1'b1; din = 4'b0100;
    tick();
    ovf_clr = 1'b0; din = 4'b0000;
    chk("t4_clrwin_ovf",  32'(overflow), 32'b0100);
    chk("t4_clrwin_drop", 32'(drop_cnt), 32'd1);
    evt_ready = 1'b1;
    tick();
    chk("t4_acc", 32'({evt_valid, pending}), 32'd0);

    // Rise on channel 1 in its own accept cycle
    do_reset();
    evt_ready = 1'b0; din = 4'b0010;
    tick();
    din = 4'b0000;
    tick();
    chk("t5_offer", 32'({evt_valid, evt_id}), 32'b101);
    evt_ready = 1'b1; din = 4'b0010;
    tick();
    din = 4'b0000;
    chk("t5_pend_kept", 32'(pending),   32'b0010);
    chk("t5_bubble",    32'(evt_valid), 32'd0);
    chk("t5_no_drop",   32'(drop_cnt),  32'd0);
    tick();
    chk("t5_second", 32'({evt_valid, evt_id}), 32'b101);
    tick();
    chk("t5_end", 32'({evt_valid, pending, drop_cnt}), 32'd0);

    // RESET while in OFFER with all channels pending
    evt_ready = 1'b0; din = 4'b1111;
    tick();
    din = 4'b0000;
    tick();
    chk("t6_offer", 32'({evt_valid, evt_id}), 32'b110);
    din = 4'b1111;
    tick();
    din = 4'b0000;
    chk("t6_multi_drop", 32'(drop_cnt), 32'd4);
    chk("t6_ovf_all",    32'(overflow), 32'b1111);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6_rst_valid", 32'(evt_valid), 32'd0);
    chk("t6_rst_id",    32'(evt_id),    32'd0);
    chk("t6_rst_pend",  32'(pending),   32'd0);
    chk("t6_rst_ovf",   32'(overflow),  32'd0);
    chk("t6_rst_drop",  32'(drop_cnt),  32'd0);
    tick();
    chk("t6_after", 32'(evt_valid), 32'd0);

    // Saturation: 75 pulses on four held-pending channels = 300 drops
    din = 4'b1111;
    tick();
    din = 4'b0000;
    tick();
    for (int p = 0; p < 63; p++) begin
      din = 4'b1111; tick();
      din = 4'b0000; tick();
    end
    chk("t7_drop252", 32'(drop_cnt), 32'd252);
    for (int p = 0; p < 12; p++) begin
      din = 4'b1111; tick();
      din = 4'b0000; tick();
    end
    chk("t7_sat", 32'(drop_cnt), 32'd255);
    chk("t7_valid_held", 32'(evt_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event scheduler.
- Each of N_CH single-bit inputs gets its own rising-edge detector, and each detected edge becomes a pending event.
- A round-robin arbiter shares one valid/ready event port among the pending channels. Each event it presents carries the originating channel id.
- The block sits between raw status/strobe lines and the single downstream consumer that services them.

Parameters:
N_CH, 4, number of input channels (2..16)
ID_W, 2, width of channel id; must equal ceil(log2(N_CH))
CNT_W, 8, width of saturating dropped-event counter

Ports:
clk  input  1  system clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
din  input  N_CH  raw channel levels, synchronous to clk
evt_valid  output  1  event offered on evt_id
evt_id  output  ID_W  channel index of offered event
evt_ready  input  1  consumer accepts event when high with evt_valid
pending  output  N_CH  registered pending-event flags
overflow  output  N_CH  sticky per-channel lost-event flags
ovf_clr  input  1  one-cycle pulse; clears overflow and drop_cnt
drop_cnt  output  CNT_W  saturating count of lost events, all channels

Behaviour:
- Clock and reset: one clock, clk. RESET is synchronous and active-high; it is sampled only on posedge clk.
- Reset values: evt_valid=0, evt_id=0, pending=0, overflow=0, drop_cnt=0, prev_din=0, rr_last=N_CH-1, FSM=IDLE.
- Reset mid-operation: any offered event is discarded. Pending events and overflow state are lost.
- Edge detect: rise[i] = din[i] & ~prev_din[i]. prev_din is registered every cycle.
  - prev_din resets to 0, so a channel held high through reset release produces exactly one event.
  - The first event appears in pending one cycle after the first post-reset sample.
- Pending set/clear, per channel i, each cycle:
  - rise[i] sets pending[i] on the next edge.
  - An accept of channel i (evt_valid & evt_ready & evt_id==i) clears pending[i].
  - If rise[i] and accept of i coincide, pending[i] stays 1. The accepted event is the old edge; the new edge becomes a new event.
- Overflow:
  - Trigger: rise[i] while pending[i]=1 and channel i is not being accepted that cycle.
  - Effect: overflow[i] sets and drop_cnt increments by one.
  - If several channels drop in the same cycle, drop_cnt increments by the number of dropping channels, saturating at 2^CNT_W-1.
  - ovf_clr clears overflow and drop_cnt. A drop in the same cycle as ovf_clr wins: overflow[i]=1 and drop_cnt=1 for a single drop.
- FSM, two states:
  - IDLE: evt_valid=0. If pending!=0, select the first set bit searching from rr_last+1 upward, wrapping modulo N_CH. Load evt_id, set evt_valid=1, go to OFFER. If pending==0, stay in IDLE.
  - OFFER: evt_valid=1 and evt_id holds stable until acceptance.
    - On evt_ready=1: clear pending[evt_id], set rr_last=evt_id, go to IDLE.
    - On evt_ready=0: stay in OFFER.
- Latency and throughput:
  - A rising din in cycle t sets pending at t+1. evt_valid rises at t+2 at the earliest.
  - Minimum 2 cycles per event, because there is one IDLE bubble after every accept.
- Handshake: once asserted, evt_valid is never withdrawn before acceptance, except by RESET. evt_ready while evt_valid=0 is ignored.
- Fairness: a channel with a pending event is granted within N_CH grants.
- The selection search is combinational over pending. The outputs evt_valid and evt_id are registered.

Test Plan:
- Reset release, din=4'b0101 held high: pending=0101 one cycle after the first post-reset sample. Events are evt_id=0 then evt_id=2, with evt_ready tied 1. No further events.
- All four channels pulse high in the same cycle, evt_ready=1: grant order 0,1,2,3 at 2-cycle spacing. Then pulse channels 3 and 0 together: order 0,3 (rr_last=3 wraps to 0).
- Channel 1 offered with evt_ready=0 for 10 cycles: evt_valid and evt_id=1 are stable throughout. On evt_ready=1 the event is accepted, pending[1] clears and evt_valid drops for one cycle.
- Channel 2 pending and held unaccepted; two further rising edges on din[2]: overflow=0100 and drop_cnt=2. Then ovf_clr: overflow=0 and drop_cnt=0.
- Rise on din[1] in the exact accept cycle of channel 1: pending[1] stays 1, a second event with evt_id=1 follows, and drop_cnt is unchanged.
- RESET asserted while in OFFER with pending=1111: next cycle all outputs are at reset values. 300 drops with CNT_W=8: drop_cnt saturates at 255.
